// File: rtl/mpsoc_dbg_or1k_ctrl_shift.sv
// JTAG Shift-DR command shifter for the per-core stall register: parity-checked
// writes issued as a one-cycle strobe, snapshot reads serialized onto TDO.
module mpsoc_dbg_or1k_ctrl_shift #(
  parameter int X              = 2,
  parameter int Y              = 2,
  parameter int Z              = 2,
  parameter int CORES_PER_TILE = 1
) (
  input  logic                                                 tck_i,
  input  logic                                                 tlr_i,
  input  logic                                                 module_select_i,
  input  logic                                                 capture_dr_i,
  input  logic                                                 shift_dr_i,
  input  logic                                                 update_dr_i,
  input  logic                                                 tdi_i,
  output logic                                                 tdo_o,
  input  logic [X-1:0][Y-1:0][Z-1:0][CORES_PER_TILE-1:0]       ctrl_reg_i,
  output logic                                                 we_o,
  output logic [X-1:0][Y-1:0][Z-1:0][CORES_PER_TILE-1:0]       data_o,
  output logic                                                 err_o
);

  // state  | meaning
  // IDLE   | no frame in progress, shifts ignored
  // OPCODE | collecting the 4-bit opcode
  // WDATA  | collecting N write data bits into staging
  // WPAR   | waiting for the write parity bit
  // WDONE  | write frame good, Update-DR issues the write
  // RDATA  | presenting snapshot bits on TDO
  // RPAR   | presenting snapshot parity on TDO
  // RDONE  | read frame finished, TDO returns to 0
  // ERR    | bad opcode or parity, waiting for Capture-DR

  localparam int N  = X * Y * Z * CORES_PER_TILE;
  localparam int CW = $clog2(N + 4);

  localparam logic [CW-1:0] LAST_OP   = CW'(3);
  localparam logic [CW-1:0] LAST_DATA = CW'(N - 1);

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_READ  = 4'h2;

  typedef enum logic [3:0] {
    IDLE, OPCODE, WDATA, WPAR, WDONE, RDATA, RPAR, RDONE, ERR
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [2:0]      op;
  logic [3:0]      opcode;
  logic            par;
  logic [N-1:0]    staging;
  logic [N-1:0]    rsh;
  logic            rpar;
  logic [N-1:0]    snap;
  logic [N-1:0]    data_q;
  logic            cnt_clr;
  logic            cnt_en;
  logic            shift_ev;

  assign opcode   = {op, tdi_i};
  assign snap     = ctrl_reg_i;
  assign data_o   = data_q;
  assign shift_ev = module_select_i & shift_dr_i & ~capture_dr_i & ~update_dr_i;

  always_comb begin
    state_nxt = state;
    if (module_select_i) begin
      if (capture_dr_i) begin
        state_nxt = OPCODE;
      end else if (update_dr_i) begin
        state_nxt = IDLE;
      end else if (shift_dr_i) begin
        case (state)
          OPCODE: if (cnt == LAST_OP) begin
            case (opcode)
              OP_NOP:   state_nxt = IDLE;
              OP_WRITE: state_nxt = WDATA;
              OP_READ:  state_nxt = RDATA;
              default:  state_nxt = ERR;
            endcase
          end
          WDATA:   if (cnt == LAST_DATA) state_nxt = WPAR;
          WPAR:    state_nxt = (par ^ tdi_i) ? ERR : WDONE;
          RDATA:   if (cnt == LAST_DATA) state_nxt = RPAR;
          RPAR:    state_nxt = RDONE;
          default: state_nxt = state;
        endcase
      end
    end
  end

  // A capture from OPCODE keeps the state but still restarts the count.
  assign cnt_clr = (module_select_i & capture_dr_i) | (state_nxt != state);
  assign cnt_en  = shift_ev & ((state == OPCODE) | (state == WDATA) | (state == RDATA));

  always_ff @(posedge tck_i) begin
    if (tlr_i) begin
      state   <= IDLE;
      cnt     <= '0;
      op      <= '0;
      par     <= 1'b0;
      staging <= '0;
      rsh     <= '0;
      rpar    <= 1'b0;
      data_q  <= '0;
      tdo_o   <= 1'b0;
      we_o    <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      state <= state_nxt;
      we_o  <= 1'b0;
      if (cnt_clr)     cnt <= '0;
      else if (cnt_en) cnt <= cnt + CW'(1);

      if (module_select_i) begin
        if (capture_dr_i) begin
          err_o <= 1'b0;
          par   <= 1'b0;
          op    <= '0;
          tdo_o <= 1'b0;
        end else if (update_dr_i) begin
          tdo_o <= 1'b0;
          if (state == WDONE) begin
            we_o   <= 1'b1;
            data_q <= staging;
          end
        end else if (shift_dr_i) begin
          case (state)
            OPCODE: begin
              op  <= {op[1:0], tdi_i};
              par <= par ^ tdi_i;
              if (cnt == LAST_OP) begin
                if (opcode == OP_READ) begin
                  rsh   <= snap;
                  rpar  <= ^snap;
                  tdo_o <= 1'b1;
                end else if (opcode != OP_NOP && opcode != OP_WRITE) begin
                  err_o <= 1'b1;
                end
              end
            end
            WDATA: begin
              staging <= {staging[N-2:0], tdi_i};
              par     <= par ^ tdi_i;
            end
            WPAR:  if (par ^ tdi_i) err_o <= 1'b1;
            RDATA: begin
              tdo_o <= rsh[N-1];
              rsh   <= {rsh[N-2:0], 1'b0};
            end
            RPAR:    tdo_o <= rpar;
            default: tdo_o <= 1'b0;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_mpsoc_dbg_or1k_ctrl_shift.sv
// Self-checking bench for the stall-control command shifter (N=8 configuration).
module tb_mpsoc_dbg_or1k_ctrl_shift;
  localparam int X = 2, Y = 2, Z = 2, CPT = 1;

  logic tck = 1'b0;
  always #5 tck = ~tck;

  logic tlr = 1'b1, sel = 1'b0, cap = 1'b0, shf = 1'b0, upd = 1'b0, tdi = 1'b0;
  logic [X-1:0][Y-1:0][Z-1:0][CPT-1:0] ctrl = '0;
  logic [X-1:0][Y-1:0][Z-1:0][CPT-1:0] data;
  logic tdo, we, err;

  int compared = 0, mismatched = 0;
  int we_cnt = 0;
  logic [7:0] exp_q[$];
  logic       tdo_q[$];
  logic [7:0] last_data = 8'h00;

  mpsoc_dbg_or1k_ctrl_shift #(.X(X), .Y(Y), .Z(Z), .CORES_PER_TILE(CPT)) dut (
    .tck_i(tck), .tlr_i(tlr), .module_select_i(sel), .capture_dr_i(cap),
    .shift_dr_i(shf), .update_dr_i(upd), .tdi_i(tdi), .tdo_o(tdo),
    .ctrl_reg_i(ctrl), .we_o(we), .data_o(data), .err_o(err)
  );

  always @(negedge tck) if (we === 1'b1) we_cnt++;

  task automatic step(input logic s, input logic c, input logic u, input logic sh, input logic d);
    sel = s; cap = c; upd = u; shf = sh; tdi = d;
    @(posedge tck);
    #1;
  endtask

  task automatic shift_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b1, 1'b0, 1'b0, 1'b1, v[i]);
  endtask

  task automatic write_frame(input logic [7:0] d, input logic bad);
    logic p;
    p = (^{4'h1, d}) ^ bad;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    shift_bits(32'h1, 4);
    shift_bits({24'h0, d}, 8);
    step(1'b1, 1'b0, 1'b0, 1'b1, p);
  endtask

  task automatic test_reset();
    logic [7:0] e;
    for (int i = 0; i < 2; i++) step(1'b1, 1'($urandom), 1'b0, 1'b1, 1'($urandom));
    compared++;
    if ({tdo, we, err} !== 3'b000 || data !== 8'h00) begin
      mismatched++;
      $display("FAIL reset_outputs: got tdo/we/err=%b data=%h expected 000 data=00", {tdo, we, err}, data);
    end
    tlr = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'($urandom));
    compared++;
    if (tdo !== 1'b0 || err !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_idle_shift: got tdo=%b err=%b expected 0 0", tdo, err);
    end
    exp_q.push_back(8'h5C);
    write_frame(8'h5C, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    e = exp_q.pop_front();
    compared++;
    if (we !== 1'b1 || data !== e) begin
      mismatched++;
      $display("FAIL reset_then_write: got we=%b data=%h expected we=1 data=%h", we, data, e);
    end
    last_data = e;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_write();
    int base;
    logic [7:0] e;
    base = we_cnt;
    exp_q.push_back(8'hA5);
    write_frame(8'hA5, 1'b0);
    compared++;
    if (err !== 1'b0 || we_cnt != base) begin
      mismatched++;
      $display("FAIL write_pre_update: got err=%b pulses=%0d expected err=0 pulses=0", err, we_cnt - base);
    end
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    e = exp_q.pop_front();
    compared++;
    if (we !== 1'b1 || data !== e) begin
      mismatched++;
      $display("FAIL write_strobe: got we=%b data=%h expected we=1 data=%h", we, data, e);
    end
    last_data = e;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    compared++;
    if (we !== 1'b0 || data !== e) begin
      mismatched++;
      $display("FAIL write_one_cycle: got we=%b data=%h expected we=0 data=%h", we, data, e);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    compared++;
    if (we_cnt != base + 1) begin
      mismatched++;
      $display("FAIL write_pulse_count: got %0d expected 1", we_cnt - base);
    end
  endtask

  task automatic test_bad_parity();
    int base;
    base = we_cnt;
    write_frame(8'h5A, 1'b1);
    compared++;
    if (err !== 1'b1) begin
      mismatched++;
      $display("FAIL badpar_err: got %b expected 1", err);
    end
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'($urandom));
    compared++;
    if (we_cnt != base || data !== last_data || err !== 1'b1) begin
      mismatched++;
      $display("FAIL badpar_no_write: got pulses=%0d data=%h err=%b expected 0 %h 1",
               we_cnt - base, data, err, last_data);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    compared++;
    if (err !== 1'b0) begin
      mismatched++;
      $display("FAIL badpar_err_clear: got %b expected 0", err);
    end
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_read();
    logic [7:0] snap;
    logic       e;
    int         k;
    snap = 8'h3C;
    ctrl = snap;
    tdo_q.push_back(1'b1);
    for (int i = 7; i >= 0; i--) tdo_q.push_back(snap[i]);
    tdo_q.push_back(^snap);
    tdo_q.push_back(1'b0);
    tdo_q.push_back(1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    shift_bits(32'h2, 4);
    ctrl = 8'hFF;
    k = 0;
    while (tdo_q.size() > 0) begin
      e = tdo_q.pop_front();
      compared++;
      if (tdo !== e) begin
        mismatched++;
        $display("FAIL read_tdo_bit%0d: got %b expected %b", k, tdo, e);
      end
      k++;
      if (tdo_q.size() > 0) step(1'b1, 1'b0, 1'b0, 1'b1, 1'($urandom));
    end
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    compared++;
    if (tdo !== 1'b0 || err !== 1'b0) begin
      mismatched++;
      $display("FAIL read_end: got tdo=%b err=%b expected 0 0", tdo, err);
    end
  endtask

  task automatic test_invalid();
    int base;
    base = we_cnt;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    shift_bits(32'h7, 4);
    compared++;
    if (err !== 1'b1 || tdo !== 1'b0) begin
      mismatched++;
      $display("FAIL invalid_op: got err=%b tdo=%b expected 1 0", err, tdo);
    end
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'($urandom));
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    compared++;
    if (we_cnt != base || tdo !== 1'b0 || err !== 1'b1) begin
      mismatched++;
      $display("FAIL invalid_update: got pulses=%0d tdo=%b err=%b expected 0 0 1", we_cnt - base, tdo, err);
    end
  endtask

  task automatic test_abort();
    int base;
    base = we_cnt;
    write_frame(8'h3C, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    compared++;
    if (we_cnt != base || data !== last_data || err !== 1'b0) begin
      mismatched++;
      $display("FAIL abort_no_write: got pulses=%0d data=%h err=%b expected 0 %h 0",
               we_cnt - base, data, err, last_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d0, d1, e;
    int base;
    d0 = 8'($urandom);
    d1 = 8'($urandom);
    base = we_cnt;
    exp_q.push_back(d0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    shift_bits(32'h1, 4);
    shift_bits({28'h0, d0[7:4]}, 4);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'($urandom), 1'b1, 1'($urandom));
    shift_bits({28'h0, d0[3:0]}, 4);
    step(1'b1, 1'b0, 1'b0, 1'b1, ^{4'h1, d0});
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    e = exp_q.pop_front();
    compared++;
    if (we !== 1'b1 || data !== e || err !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_first_deselect: got we=%b data=%h err=%b expected 1 %h 0", we, data, err, e);
    end
    exp_q.push_back(d1);
    write_frame(d1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    e = exp_q.pop_front();
    compared++;
    if (we !== 1'b1 || data !== e) begin
      mismatched++;
      $display("FAIL b2b_second: got we=%b data=%h expected 1 %h", we, data, e);
    end
    last_data = e;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    compared++;
    if (we_cnt != base + 2) begin
      mismatched++;
      $display("FAIL b2b_pulse_count: got %0d expected 2", we_cnt - base);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_bad_parity();
    test_read();
    test_invalid();
    test_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
